// File: rtl/sequenciador_ula_pkg.sv
// seq_ula_pkg -- shared definitions for the sequenciador_ula slice.
//
// Contents:
//   OP_*       ALU select codes seen on the request bus and on ula_op.
//   estado_t   Encoding of the sequencer FSM.
//   classe_t   How an accepted op is routed through the FSM.
//   classifica Maps an op code to its classe_t.
//
// Build option: SEQ_ULA_DIV_EN. When it is undefined, DIVI (op 3) is
// classified as illegal.
package seq_ula_pkg;

  localparam logic [5:0] OP_SOMA  = 6'd0;
  localparam logic [5:0] OP_SUBT  = 6'd1;
  localparam logic [5:0] OP_MULT  = 6'd2;
  localparam logic [5:0] OP_DIVI  = 6'd3;
  localparam logic [5:0] OP_MOVER = 6'd16;
  localparam logic [5:0] OP_NOP   = 6'd31;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    SIMPLES = 2'd1,
    ITERA   = 2'd2,
    PRONTO  = 2'd3
  } estado_t;

  typedef enum logic [2:0] {
    CL_SIMPLES,
    CL_NOP,
    CL_MULT,
    CL_DIVI,
    CL_ILEGAL
  } classe_t;

  // Ops 0, 1 and 4..16 are resolved by the external combinational ALU.
  function automatic classe_t classifica(input logic [5:0] op);
    classe_t c;
    if (op == OP_NOP) begin
      c = CL_NOP;
    end else if (op == OP_MULT) begin
      c = CL_MULT;
`ifdef SEQ_ULA_DIV_EN
    end else if (op == OP_DIVI) begin
      c = CL_DIVI;
`endif
    end else if (op == OP_SOMA || op == OP_SUBT ||
                 (op > OP_DIVI && op <= OP_MOVER)) begin
      c = CL_SIMPLES;
    end else begin
      c = CL_ILEGAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/sequenciador_ula_if.sv
// sequenciador_ula_if -- request, result and external-ALU bus of the sequencer.
//
// Signals:
//   in_valid/in_ready/op/a/b              request handshake and operands
//   ula_op/ula_a/ula_b/ula_res            external combinational ALU
//   out_valid/out_ready/resultado/resto/erro  result handshake
//
// Modports:
//   slave   the sequencer itself
//   master  the requester/consumer environment (also supplies ula_res)
interface sequenciador_ula_if #(
  parameter int LARGURA = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [5:0]         op;
  logic [LARGURA-1:0] a;
  logic [LARGURA-1:0] b;
  logic [5:0]         ula_op;
  logic [LARGURA-1:0] ula_a;
  logic [LARGURA-1:0] ula_b;
  logic [LARGURA-1:0] ula_res;
  logic               out_valid;
  logic               out_ready;
  logic [LARGURA-1:0] resultado;
  logic [LARGURA-1:0] resto;
  logic               erro;

  modport slave (
    input  in_valid, op, a, b, ula_res, out_ready,
    output in_ready, ula_op, ula_a, ula_b, out_valid, resultado, resto, erro
  );

  modport master (
    output in_valid, op, a, b, ula_res, out_ready,
    input  in_ready, ula_op, ula_a, ula_b, out_valid, resultado, resto, erro
  );
endinterface

// File: rtl/sequenciador_ula_mult_div.sv
// mult_div_iterativo -- LARGURA-step unsigned shift-add multiplier and,
// when SEQ_ULA_DIV_EN is defined, restoring shift-subtract divider.
//
// Ports:
//   clock_i, reset_i      clock / asynchronous active-high reset
//   start_i               loads operands; iterations follow on the next edges
//   modo_i                0 = multiply, 1 = divide (sampled with start_i)
//   a_i, b_i              multiplicand/dividend, multiplier/divisor
//   fim_o                 high during the cycle whose edge performs the last step
//   produto_quociente_o   result of the step being performed this cycle
//   resto_o               remainder of that step (0 when multiplying)
//
// The outputs are the combinational next values, so the owner registers the
// final result on the same edge that performs iteration LARGURA.
module mult_div_iterativo #(
  parameter int LARGURA = 32
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               modo_i,
  input  logic [LARGURA-1:0] a_i,
  input  logic [LARGURA-1:0] b_i,
  output logic               fim_o,
  output logic [LARGURA-1:0] produto_quociente_o,
  output logic [LARGURA-1:0] resto_o
);

  localparam int CW = $clog2(LARGURA + 1);

  logic          ocupado_q;
  logic [CW-1:0] cont_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ocupado_q <= 1'b0;
      cont_q    <= '0;
    end else if (start_i) begin
      ocupado_q <= 1'b1;
      cont_q    <= '0;
    end else if (ocupado_q) begin
      if (cont_q == CW'(LARGURA - 1)) begin
        ocupado_q <= 1'b0;
      end else begin
        cont_q <= cont_q + CW'(1);
      end
    end
  end

  assign fim_o = ocupado_q && (cont_q == CW'(LARGURA - 1));

  // Multiplier: only the low LARGURA bits of the product are kept.
  logic [LARGURA-1:0] prod_q, mcand_q, mplier_q, prod_d;

  assign prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clock_i) begin
    if (start_i) begin
      prod_q   <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
    end else if (ocupado_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

`ifdef SEQ_ULA_DIV_EN
  // Restoring divider: the dividend is shifted MSB-first out of quo_q into
  // the partial remainder while quotient bits are shifted in at the bottom.
  logic               modo_q;
  logic [LARGURA-1:0] quo_q, rem_q, dvs_q;
  logic [LARGURA:0]   desloc_d;
  logic               cabe_d;
  logic [LARGURA-1:0] rem_d, quo_d;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      modo_q <= 1'b0;
    end else if (start_i) begin
      modo_q <= modo_i;
    end
  end

  assign desloc_d = {rem_q, quo_q[LARGURA-1]};
  assign cabe_d   = (desloc_d >= {1'b0, dvs_q});
  // When the divisor fits, the true difference is below dvs_q, so the
  // modulo-2^LARGURA subtraction is exact.
  assign rem_d    = cabe_d ? (desloc_d[LARGURA-1:0] - dvs_q) : desloc_d[LARGURA-1:0];
  assign quo_d    = {quo_q[LARGURA-2:0], cabe_d};

  always_ff @(posedge clock_i) begin
    if (start_i) begin
      quo_q <= a_i;
      rem_q <= '0;
      dvs_q <= b_i;
    end else if (ocupado_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign produto_quociente_o = modo_q ? quo_d : prod_d;
  assign resto_o             = modo_q ? rem_d : '0;
`else
  logic unused_modo;
  assign unused_modo         = modo_i;
  assign produto_quociente_o = prod_d;
  assign resto_o             = '0;
`endif

endmodule

// File: rtl/sequenciador_ula.sv
// sequenciador_ula -- sequences requests through an external combinational
// ALU or the internal iterative multiplier/divider and holds each result
// until the consumer takes it.
//
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous, active-high; drops any operation in flight
//   bus    sequenciador_ula_if.slave (request, external ALU, result)
//
// Latency from the accepting edge to out_valid: 1 cycle for NOP, illegal ops
// and DIVI by zero; 2 cycles for ALU ops; LARGURA+1 cycles for MULT/DIVI.
//
// Build option: SEQ_ULA_DIV_EN includes the divider; without it op 3 is
// treated as an illegal op.
module sequenciador_ula
  import seq_ula_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic                clock,
  input  logic                reset,
  sequenciador_ula_if.slave   bus
);

  estado_t            estado_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               erro_q;
  logic [5:0]         ula_op_q;
  logic [LARGURA-1:0] ula_a_q, ula_b_q;
  logic [LARGURA-1:0] resultado_q, resto_q;

  classe_t            classe_d;
  logic               aceita_d;
  logic               inicia_d;
  logic               modo_d;
  logic               fim;
  logic [LARGURA-1:0] md_res, md_resto;

  assign classe_d = classifica(bus.op);
  assign aceita_d = (estado_q == OCIOSO) && bus.in_valid;

  // The iterative unit loads its operands on the accepting edge, straight
  // from the bus, so its LARGURA steps line up with the ITERA cycles.
  always_comb begin
    inicia_d = 1'b0;
    modo_d   = 1'b0;
    if (aceita_d) begin
      if (classe_d == CL_MULT) begin
        inicia_d = 1'b1;
      end
`ifdef SEQ_ULA_DIV_EN
      if (classe_d == CL_DIVI && bus.b != '0) begin
        inicia_d = 1'b1;
        modo_d   = 1'b1;
      end
`endif
    end
  end

  mult_div_iterativo #(
    .LARGURA(LARGURA)
  ) u_mult_div (
    .clock_i             (clock),
    .reset_i             (reset),
    .start_i             (inicia_d),
    .modo_i              (modo_d),
    .a_i                 (bus.a),
    .b_i                 (bus.b),
    .fim_o               (fim),
    .produto_quociente_o (md_res),
    .resto_o             (md_resto)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      in_ready_q  <= 1'b1;
      ula_op_q    <= OP_NOP;
      ula_a_q     <= '0;
      ula_b_q     <= '0;
      out_valid_q <= 1'b0;
      resultado_q <= '0;
      resto_q     <= '0;
      erro_q      <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (aceita_d) begin
            in_ready_q <= 1'b0;
            case (classe_d)
              CL_SIMPLES: begin
                estado_q <= SIMPLES;
                ula_op_q <= bus.op;
                ula_a_q  <= bus.a;
                ula_b_q  <= bus.b;
              end
              CL_NOP: begin
                estado_q    <= PRONTO;
                out_valid_q <= 1'b1;
                resultado_q <= bus.a;
                resto_q     <= '0;
                erro_q      <= 1'b0;
              end
              CL_MULT: begin
                estado_q <= ITERA;
              end
`ifdef SEQ_ULA_DIV_EN
              CL_DIVI: begin
                if (bus.b == '0) begin
                  estado_q    <= PRONTO;
                  out_valid_q <= 1'b1;
                  resultado_q <= '1;
                  resto_q     <= bus.a;
                  erro_q      <= 1'b1;
                end else begin
                  estado_q <= ITERA;
                end
              end
`endif
              default: begin
                estado_q    <= PRONTO;
                out_valid_q <= 1'b1;
                resultado_q <= '0;
                resto_q     <= '0;
                erro_q      <= 1'b1;
              end
            endcase
          end
        end
        SIMPLES: begin
          estado_q    <= PRONTO;
          ula_op_q    <= OP_NOP;
          ula_a_q     <= '0;
          ula_b_q     <= '0;
          out_valid_q <= 1'b1;
          resultado_q <= bus.ula_res;
          resto_q     <= '0;
          erro_q      <= 1'b0;
        end
        ITERA: begin
          if (fim) begin
            estado_q    <= PRONTO;
            out_valid_q <= 1'b1;
            resultado_q <= md_res;
            resto_q     <= md_resto;
            erro_q      <= 1'b0;
          end
        end
        PRONTO: begin
          // in_ready only rises on this edge, so a new request cannot be
          // taken in the same cycle the result is handed over.
          if (bus.out_ready) begin
            estado_q    <= OCIOSO;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ula_op    = ula_op_q;
  assign bus.ula_a     = ula_a_q;
  assign bus.ula_b     = ula_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.resultado = resultado_q;
  assign bus.resto     = resto_q;
  assign bus.erro      = erro_q;

endmodule

// File: tb/tb_sequenciador_ula.sv
// tb_sequenciador_ula -- randomized, self-checking bench for sequenciador_ula
// with a behavioural reference model and an external ALU model.
module tb_sequenciador_ula;

  localparam int L = 32;

  logic clock;
  logic reset;
  bit   chk_on;
  int   nchk;
  int   nerr;

  sequenciador_ula_if #(.LARGURA(L)) bus ();

  sequenciador_ula #(
    .LARGURA(L)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External combinational ALU.
  function automatic logic [L-1:0] alu_ext(input logic [5:0] op,
                                           input logic [L-1:0] a,
                                           input logic [L-1:0] b);
    logic [L-1:0] r;
    case (op)
      6'd0:    r = a + b;
      6'd1:    r = a - b;
      6'd4:    r = a & b;
      6'd5:    r = a | b;
      6'd6:    r = a ^ b;
      6'd7:    r = ~(a | b);
      6'd8:    r = (a < b) ? 32'd1 : 32'd0;
      6'd9:    r = a << b[4:0];
      6'd10:   r = a >> b[4:0];
      6'd16:   r = a;
      default: r = a ^ (b << 1);
    endcase
    return r;
  endfunction

  assign bus.ula_res = alu_ext(bus.ula_op, bus.ula_a, bus.ula_b);

  // Reference model: what each accepted request must produce.
  typedef struct {
    int           lat;
    logic [L-1:0] r;
    logic [L-1:0] rs;
    logic         e;
    bit           s;
  } esperado_t;

  function automatic esperado_t modelo(input logic [5:0] op,
                                       input logic [L-1:0] a,
                                       input logic [L-1:0] b);
    esperado_t x;
    logic [63:0] p;
    x.s  = 1'b0;
    x.rs = '0;
    x.e  = 1'b0;
    if (op == 6'd31) begin
      x.lat = 1;
      x.r   = a;
    end else if (op == 6'd2) begin
      p     = 64'(a) * 64'(b);
      x.lat = L + 1;
      x.r   = p[L-1:0];
    end else if (op == 6'd3) begin
`ifdef SEQ_ULA_DIV_EN
      if (b == '0) begin
        x.lat = 1;
        x.r   = '1;
        x.rs  = a;
        x.e   = 1'b1;
      end else begin
        x.lat = L + 1;
        x.r   = a / b;
        x.rs  = a % b;
      end
`else
      x.lat = 1;
      x.r   = '0;
      x.e   = 1'b1;
`endif
    end else if (op <= 6'd16) begin
      x.lat = 2;
      x.r   = alu_ext(op, a, b);
      x.s   = 1'b1;
    end else begin
      x.lat = 1;
      x.r   = '0;
      x.e   = 1'b1;
    end
    return x;
  endfunction

  bit           m_busy;
  int           m_k;
  logic [5:0]   m_op;
  logic [L-1:0] m_a, m_b;
  esperado_t    m_exp;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        m_busy <= 1'b1;
        m_k    <= 1;
        m_op   <= bus.op;
        m_a    <= bus.a;
        m_b    <= bus.b;
        m_exp  <= modelo(bus.op, bus.a, bus.b);
      end
    end else begin
      if (m_k >= m_exp.lat && bus.out_ready) begin
        m_busy <= 1'b0;
      end else if (m_k < m_exp.lat) begin
        m_k <= m_k + 1;
      end
    end
  end

  task automatic chk(input string nome, input logic [63:0] atual, input logic [63:0] req);
    nchk++;
    if (atual !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nome, atual, req, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_on && !reset) begin
      if (!m_busy) begin
        chk("idle in_ready", 64'(bus.in_ready), 64'd1);
        chk("idle out_valid", 64'(bus.out_valid), 64'd0);
        chk("idle ula_op", 64'(bus.ula_op), 64'd31);
        chk("idle ula_a", 64'(bus.ula_a), 64'd0);
        chk("idle ula_b", 64'(bus.ula_b), 64'd0);
      end else begin
        chk("busy in_ready", 64'(bus.in_ready), 64'd0);
        chk("ula_op", 64'(bus.ula_op), (m_exp.s && m_k == 1) ? 64'(m_op) : 64'd31);
        chk("ula_a", 64'(bus.ula_a), (m_exp.s && m_k == 1) ? 64'(m_a) : 64'd0);
        chk("ula_b", 64'(bus.ula_b), (m_exp.s && m_k == 1) ? 64'(m_b) : 64'd0);
        chk("out_valid", 64'(bus.out_valid), (m_k >= m_exp.lat) ? 64'd1 : 64'd0);
        if (m_k >= m_exp.lat) begin
          chk("resultado", 64'(bus.resultado), 64'(m_exp.r));
          chk("resto", 64'(bus.resto), 64'(m_exp.rs));
          chk("erro", 64'(bus.erro), 64'(m_exp.e));
        end
      end
    end
  end

  // Presents a request for one cycle; returns #1 after the accepting edge.
  task automatic envia(input logic [5:0] op, input logic [L-1:0] a, input logic [L-1:0] b);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Releases a presented result and returns #1 after the releasing edge.
  task automatic libera();
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic dirigido(input string nome, input logic [5:0] op,
                          input logic [L-1:0] a, input logic [L-1:0] b,
                          input int lat, input logic [5:0] ula_op_1,
                          input logic [L-1:0] r, input logic [L-1:0] rs,
                          input logic e, input bit segura);
    int k;
    envia(op, a, b);
    k = 1;
    forever begin
      @(negedge clock);
      if (k == 1) chk({nome, " ula_op cycle1"}, 64'(bus.ula_op), 64'(ula_op_1));
      if (bus.out_valid) break;
      k++;
      if (k > 100) begin
        chk({nome, " out_valid timeout"}, 64'(bus.out_valid), 64'd1);
        break;
      end
    end
    chk({nome, " latency"}, 64'(k), 64'(lat));
    chk({nome, " resultado"}, 64'(bus.resultado), 64'(r));
    chk({nome, " resto"}, 64'(bus.resto), 64'(rs));
    chk({nome, " erro"}, 64'(bus.erro), 64'(e));
    if (segura) begin
      repeat (5) @(negedge clock);
      chk({nome, " held in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({nome, " held out_valid"}, 64'(bus.out_valid), 64'd1);
      chk({nome, " held resultado"}, 64'(bus.resultado), 64'(r));
    end
    libera();
  endtask

  // Random transaction with junk on the request inputs while busy.
  task automatic transacao(input logic [5:0] op, input logic [L-1:0] a, input logic [L-1:0] b);
    int k;
    envia(op, a, b);
    bus.out_ready = 1'($urandom_range(0, 1));
    k = 1;
    forever begin
      @(negedge clock);
      if (bus.out_valid) break;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.op       = 6'($urandom);
      bus.a        = $urandom;
      bus.b        = $urandom;
      k++;
      if (k > 100) begin
        chk("random out_valid timeout", 64'(bus.out_valid), 64'd1);
        break;
      end
    end
    if (!bus.out_ready) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock);
        #1;
      end
    end
    libera();
  endtask

  initial begin
    logic [5:0] op;
    logic [L-1:0] a, b;
    int sel;
    nchk          = 0;
    nerr          = 0;
    chk_on        = 1'b0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    #12;
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset ula_op", 64'(bus.ula_op), 64'd31);
    chk("reset ula_a", 64'(bus.ula_a), 64'd0);
    chk("reset resultado", 64'(bus.resultado), 64'd0);
    chk("reset resto", 64'(bus.resto), 64'd0);
    chk("reset erro", 64'(bus.erro), 64'd0);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    chk_on = 1'b1;

    dirigido("soma", 6'd0, 32'd5, 32'd7, 2, 6'd0, 32'd12, 32'd0, 1'b0, 1'b0);
    dirigido("mult", 6'd2, 32'h0001_0003, 32'h0000_0010, 33, 6'd31, 32'h0010_0030, 32'd0, 1'b0, 1'b0);
`ifdef SEQ_ULA_DIV_EN
    dirigido("divi", 6'd3, 32'd100, 32'd7, 33, 6'd31, 32'd14, 32'd2, 1'b0, 1'b0);
    dirigido("divi0", 6'd3, 32'd9, 32'd0, 1, 6'd31, 32'hFFFF_FFFF, 32'd9, 1'b1, 1'b0);
`else
    dirigido("divi off", 6'd3, 32'd100, 32'd7, 1, 6'd31, 32'd0, 32'd0, 1'b1, 1'b0);
`endif
    dirigido("op20", 6'd20, 32'd3, 32'd4, 1, 6'd31, 32'd0, 32'd0, 1'b1, 1'b0);
    dirigido("nop", 6'd31, 32'hA5, 32'd1, 1, 6'd31, 32'hA5, 32'd0, 1'b0, 1'b0);
    dirigido("mover", 6'd16, 32'h1234, 32'd9, 2, 6'd16, 32'h1234, 32'd0, 1'b0, 1'b0);
    dirigido("subt hold", 6'd1, 32'd10, 32'd3, 2, 6'd1, 32'd7, 32'd0, 1'b0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (sel <= 5) begin
        op = 6'($urandom_range(4, 16));
        if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 1));
      end else if (sel == 6) begin
        op = 6'd2;
      end else if (sel == 7) begin
        op = 6'd3;
        if ($urandom_range(0, 3) == 0) b = '0;
      end else if (sel == 8) begin
        op = 6'd31;
      end else begin
        op = 6'($urandom_range(17, 30));
      end
      transacao(op, a, b);
    end

    // Reset in the middle of a multiplication.
    envia(6'd2, 32'd1234, 32'd5678);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset in_ready", 64'(bus.in_ready), 64'd1);
    chk("midreset out_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset ula_op", 64'(bus.ula_op), 64'd31);
    chk("midreset resultado", 64'(bus.resultado), 64'd0);
    chk("midreset erro", 64'(bus.erro), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      chk("after reset out_valid", 64'(bus.out_valid), 64'd0);
    end

    dirigido("soma after reset", 6'd0, 32'd1, 32'd2, 2, 6'd0, 32'd3, 32'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
